// File: rtl/cpu_defs.sv
// Shared CPU definitions: memory-op encodings, MEM-stage FSM states and
// the default memory map used by EXE, EXE_MEM and the MEM stage.
package cpu_defs;

  localparam logic [3:0] MEMOP_NONE = 4'd0;
  localparam logic [3:0] MEMOP_LB   = 4'd1;
  localparam logic [3:0] MEMOP_LBU  = 4'd2;
  localparam logic [3:0] MEMOP_LH   = 4'd3;
  localparam logic [3:0] MEMOP_LHU  = 4'd4;
  localparam logic [3:0] MEMOP_LW   = 4'd5;
  localparam logic [3:0] MEMOP_SB   = 4'd6;
  localparam logic [3:0] MEMOP_SH   = 4'd7;
  localparam logic [3:0] MEMOP_SW   = 4'd8;

  // Everything at or above this byte address is memory-mapped IO.
  localparam logic [31:0] IO_BASE_DEFAULT = 32'hFFFF_FC00;
  localparam int          RAM_AW_DEFAULT  = 14;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RD_WAIT = 2'd1,
    ST_RD_HOLD = 2'd2
  } mem_state_e;

  function automatic logic isLoadOp(input logic [3:0] op);
    return (op >= MEMOP_LB) && (op <= MEMOP_LW);
  endfunction

  function automatic logic isStoreOp(input logic [3:0] op);
    return (op >= MEMOP_SB) && (op <= MEMOP_SW);
  endfunction

endpackage

// File: rtl/mem_access_load_align.sv
// Load formatter: picks the addressed byte/half out of a raw 32-bit word
// and sign- or zero-extends it according to the load op.
module load_align
  import cpu_defs::*;
(
  input  logic [3:0]  i_op,
  input  logic [1:0]  i_lane,
  input  logic [31:0] i_raw,
  output logic [31:0] o_result
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Lane extraction followed by the op-dependent extension.
  always_comb begin
    w_byte   = i_raw[{i_lane, 3'b000} +: 8];
    w_half   = i_lane[1] ? i_raw[31:16] : i_raw[15:0];
    o_result = 32'd0;
    case (i_op)
      MEMOP_LB:  o_result = {{24{w_byte[7]}}, w_byte};
      MEMOP_LBU: o_result = {24'd0, w_byte};
      MEMOP_LH:  o_result = {{16{w_half[15]}}, w_half};
      MEMOP_LHU: o_result = {16'd0, w_half};
      MEMOP_LW:  o_result = i_raw;
      default:   o_result = 32'd0;
    endcase
  end

endmodule

// File: rtl/mem_access.sv
// MEM pipeline stage: routes the registered memory op to data RAM or IO,
// commits stores with byte enables, and turns each load into a one-cycle
// stall followed by an aligned, extended writeback. The wb_* bus doubles as
// the MEM-stage forwarding bus toward ID.
module mem_access
  import cpu_defs::*;
#(
  parameter logic [31:0] IO_BASE = IO_BASE_DEFAULT,
  parameter int          RAM_AW  = RAM_AW_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic [3:0]        mem_op,
  input  logic [31:0]       mem_addr,
  input  logic [31:0]       mem_data,
  input  logic              in_we,
  input  logic [4:0]        in_write_reg,
  input  logic [31:0]       in_write_data,
  output logic [RAM_AW-1:0] ram_addr,
  output logic              ram_re,
  output logic [3:0]        ram_be,
  output logic [31:0]       ram_write_data,
  input  logic [31:0]       ram_read_data,
  output logic [31:0]       io_addr,
  output logic              io_re,
  output logic [3:0]        io_be,
  output logic [31:0]       io_write_data,
  input  logic [31:0]       io_read_data,
  output logic              stall_req,
  output logic              misalign,
  output logic              wb_we,
  output logic [4:0]        wb_write_reg,
  output logic [31:0]       wb_write_data
);

  mem_state_e  r_state;
  logic [3:0]  r_op;
  logic [1:0]  r_lane;
  logic        r_isIo;
  logic [4:0]  r_writeReg;
  logic [31:0] r_hold;

  logic        w_isLoad;
  logic        w_isStore;
  logic        w_misaligned;
  logic        w_isIo;
  logic [3:0]  w_storeBe;
  logic [31:0] w_storeData;
  logic [31:0] w_rawWord;
  logic [31:0] w_loadResult;

  // Decode the presented op: class, alignment and target region.
  always_comb begin
    w_isLoad     = isLoadOp(mem_op);
    w_isStore    = isStoreOp(mem_op);
    w_misaligned = 1'b0;
    case (mem_op)
      MEMOP_LH, MEMOP_LHU, MEMOP_SH: w_misaligned = mem_addr[0];
      MEMOP_LW, MEMOP_SW:            w_misaligned = (mem_addr[1:0] != 2'b00);
      default:                       w_misaligned = 1'b0;
    endcase
    w_isIo = (mem_addr >= IO_BASE);
  end

  // Store lane enables and lane-replicated store data.
  always_comb begin
    w_storeBe   = 4'b0000;
    w_storeData = 32'd0;
    case (mem_op)
      MEMOP_SB: begin
        w_storeBe   = 4'b0001 << mem_addr[1:0];
        w_storeData = {4{mem_data[7:0]}};
      end
      MEMOP_SH: begin
        w_storeBe   = 4'b0011 << {mem_addr[1], 1'b0};
        w_storeData = {2{mem_data[15:0]}};
      end
      MEMOP_SW: begin
        w_storeBe   = 4'b1111;
        w_storeData = mem_data;
      end
      default: begin
        w_storeBe   = 4'b0000;
        w_storeData = 32'd0;
      end
    endcase
  end

  // The read source was fixed at issue; never re-decode it from the address.
  assign w_rawWord = r_isIo ? io_read_data : ram_read_data;

  load_align u_loadAlign (
    .i_op     (r_op),
    .i_lane   (r_lane),
    .i_raw    (w_rawWord),
    .o_result (w_loadResult)
  );

  // Output steering per state; everything is forced low while in reset.
  always_comb begin
    ram_addr       = '0;
    ram_re         = 1'b0;
    ram_be         = 4'b0000;
    ram_write_data = 32'd0;
    io_addr        = 32'd0;
    io_re          = 1'b0;
    io_be          = 4'b0000;
    io_write_data  = 32'd0;
    stall_req      = 1'b0;
    misalign       = 1'b0;
    wb_we          = 1'b0;
    wb_write_reg   = 5'd0;
    wb_write_data  = 32'd0;
    if (!rst) begin
      ram_addr = mem_addr[RAM_AW+1:2];
      io_addr  = mem_addr;
      case (r_state)
        ST_IDLE: begin
          if (w_isLoad && w_misaligned) begin
            misalign     = 1'b1;
            wb_we        = 1'b1;
            wb_write_reg = in_write_reg;
          end else if (w_isLoad) begin
            stall_req = 1'b1;
            ram_re    = !w_isIo;
            io_re     = w_isIo;
          end else begin
            wb_we         = in_we;
            wb_write_reg  = in_write_reg;
            wb_write_data = in_write_data;
            if (w_isStore && w_misaligned) begin
              misalign = 1'b1;
            end else if (w_isStore) begin
              if (w_isIo) begin
                io_write_data = w_storeData;
                io_be         = stall ? 4'b0000 : w_storeBe;
              end else begin
                ram_write_data = w_storeData;
                ram_be         = stall ? 4'b0000 : w_storeBe;
              end
            end
          end
        end
        ST_RD_WAIT: begin
          wb_we         = 1'b1;
          wb_write_reg  = r_writeReg;
          wb_write_data = w_loadResult;
        end
        ST_RD_HOLD: begin
          wb_we         = 1'b1;
          wb_write_reg  = r_writeReg;
          wb_write_data = r_hold;
        end
        default: begin
          wb_we = 1'b0;
        end
      endcase
    end
  end

  // Load FSM: latch the load at issue, then wait out read latency and stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_op       <= MEMOP_NONE;
      r_lane     <= 2'b00;
      r_isIo     <= 1'b0;
      r_writeReg <= 5'd0;
      r_hold     <= 32'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_isLoad && !w_misaligned) begin
            r_op       <= mem_op;
            r_lane     <= mem_addr[1:0];
            r_isIo     <= w_isIo;
            r_writeReg <= in_write_reg;
            r_state    <= ST_RD_WAIT;
          end
        end
        ST_RD_WAIT: begin
          if (stall) begin
            r_hold  <= w_loadResult;
            r_state <= ST_RD_HOLD;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_RD_HOLD: begin
          if (!stall) begin
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
